ahb_calc_regbank: RTL
=====================

// Module: ahb_calc_regbank
// PURPOSE
//  AHB-Lite slave exposing NUM_CH independent calculator channels, each with its own mode, operand A/B and result registers.
//  Each channel has a per-channel req/ack handshake FSM toward an external calc engine, sticky done status and a maskable interrupt.
//  Parametrised successor of the single-channel calculator register slave; sits between the AHB fabric and the calc datapaths.
// PARAMETERS
//  NUM_CH  4   number of calculator channels, legal 1..7
//  OP_W    16  operand width per channel, legal 1..32
//  RES_W   32  result width per channel, legal 1..32
//  ADDR_W  8   haddr width
// PORTS
//  hclk         in   1             bus clock; the only clock
//  hreset       in   1             synchronous, active-high reset
//  hsel         in   1             slave select
//  hwrite       in   1             1=write, 0=read
//  hready       in   1             bus ready (previous transfer complete)
//  hsize        in   3             ignored; every access is treated as a 32-bit word
//  htrans       in   2             IDLE/BUSY/NONSEQ/SEQ
//  hburst       in   3             ignored; every beat is decoded individually
//  hwdata       in   32            write data (data phase)
//  haddr        in   ADDR_W        byte address
//  hready_resp  out  1             slave ready
//  hresp        out  2             00 OKAY, 01 ERROR
//  hrdata       out  32            read data (data phase)
//  calc_req     out  NUM_CH        per-channel request, level until ack
//  calc_mode    out  2*NUM_CH      channel c at [2c+1:2c]
//  calc_opa     out  OP_W*NUM_CH   operand A, channel c at [c*OP_W +: OP_W]
//  calc_opb     out  OP_W*NUM_CH   operand B, channel c at [c*OP_W +: OP_W]
//  calc_ack     in   NUM_CH        per-channel completion pulse
//  calc_result  in   RES_W*NUM_CH  result, valid in the cycle calc_ack is high
//  irq          out  1             OR over channels of (done & irq_en)
// BEHAVIOUR
//  Decode:
//   - Address phase is captured when hsel && hready; htrans, hwrite and haddr are registered.
//   - When the capture condition is false, registered htrans is forced to IDLE.
//   - A transfer is valid when registered htrans is NONSEQ or SEQ. Writes use hwdata in the following cycle.
//  Channel map (channel c, base = c*0x20); unlisted bits read 0:
//   - +0x00 CTRL: [0] START, write-1 pulse, reads 0; [2:1] MODE.
//   - +0x04 OPA.
//   - +0x08 OPB.
//   - +0x0C RESULT: read-only.
//   - +0x10 STAT: [0] BUSY, read-only; [1] DONE, sticky, write-1-to-clear.
//  Global registers:
//   - 0xF0 IRQ_EN: [NUM_CH-1:0].
//   - 0xF4 IRQ_STAT: read-only, DONE & IRQ_EN.
//  Channel FSM, IDLE <-> BUSY:
//   - IDLE->BUSY on a START=1 write; calc_req goes high the next cycle.
//   - BUSY: calc_req held high.
//   - BUSY->IDLE in the cycle calc_ack is seen; in that cycle RESULT <= calc_result and DONE <= 1.
//   - calc_req drops the next cycle.
//   - calc_ack while IDLE is ignored.
//  Busy protection:
//   - START, MODE, OPA and OPB writes while BUSY are dropped.
//   - Operands and mode stay stable for the whole request.
//  Simultaneous events:
//   - Same-cycle DONE W1C write and calc_ack: set wins.
//   - CTRL write with START=0 updates MODE only.
//  hrdata:
//   - Combinational from the registered address during a valid read; 0 otherwise.
//   - Unmapped offsets and channels >= NUM_CH read 0.
//  hready_resp=1 and hresp=OKAY always, except as described under CONFIGURATION.
//  irq is registered: 1 cycle after DONE/IRQ_EN change.
//  Reset values:
//   - All registers and FSMs are 0/IDLE; calc_req=0; irq=0; hrdata=0; hready_resp=1; hresp=OKAY.
//   - Reset mid-operation abandons the request: calc_req low the cycle after reset asserts, any late ack ignored.
// CONFIGURATION
//  AHB_CALC_ERR_RESP_EN defined:
//   - These accesses produce a two-cycle ERROR response:
//     * a write dropped because the channel is BUSY;
//     * any access to an unmapped address;
//     * a write to RESULT or IRQ_STAT.
//   - Cycle 1: hready_resp=0, hresp=ERROR. Cycle 2: hready_resp=1, hresp=ERROR.
//   - An address phase presented during cycle 1 is not captured.
//  Not defined: such accesses are silently ignored and respond OKAY with zero wait states.
// STRUCTURE
//  Shared package ahb_calc_pkg:
//   - htrans codes IDLE/BUSY/NONSEQ/SEQ, hresp codes.
//   - Register offsets CTRL/OPA/OPB/RESULT/STAT, CH_STRIDE=0x20, IRQ_EN_ADDR=0xF0, IRQ_STAT_ADDR=0xF4.
//   - Channel FSM state encoding.
//  Sub-module ahb_calc_chan: one channel's registers + FSM, generated NUM_CH times.
//  Top holds address-phase capture, decode, read mux, IRQ and error-response logic.
// TESTING
//  1. Reset, then read every register -> all 0; hready_resp=1, hresp=00, calc_req=0.
//  2. Ch1: OPA=0x0012, OPB=0x0034, CTRL=0x5 -> calc_mode[3:2]=2, calc_req[1]=1.
//     Ack after 3 cycles with result 0x46 -> RESULT=0x46, STAT=0x2, calc_req[1]=0.
//  3. Ch0 BUSY, write OPA=0xFFFF -> OPA unchanged, calc_opa[15:0] unchanged.
//     With AHB_CALC_ERR_RESP_EN: ERROR, 1 wait state.
//  4. IRQ_EN=0x4, ch2 completes -> irq=1 one cycle later, IRQ_STAT=0x4.
//     Write STAT=0x2 to ch2 -> irq=0. W1C and ack in the same cycle -> DONE stays 1.
//  5. Back-to-back SEQ burst writing OPA, OPB, CTRL of ch3 with hready held high -> all three take effect, no wait states.
//  6. Assert hreset while ch0 BUSY -> calc_req=0 next cycle, STAT=0. A later calc_ack[0] leaves RESULT=0 and DONE=0.

Source files
------------

// File: rtl/ahb_calc_pkg.sv
// Shared constants for the AHB calculator register bank: bus codes, register map
// offsets and the per-channel handshake FSM encoding.
package ahb_calc_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [4:0] CTRL_OFF   = 5'h00;
    localparam logic [4:0] OPA_OFF    = 5'h04;
    localparam logic [4:0] OPB_OFF    = 5'h08;
    localparam logic [4:0] RESULT_OFF = 5'h0C;
    localparam logic [4:0] STAT_OFF   = 5'h10;

    localparam logic [7:0] CH_STRIDE     = 8'h20;
    localparam logic [7:0] IRQ_EN_ADDR   = 8'hF0;
    localparam logic [7:0] IRQ_STAT_ADDR = 8'hF4;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

endpackage

// File: rtl/ahb_calc_chan.sv
// One calculator channel: MODE/OPA/OPB/RESULT registers, sticky DONE and the
// IDLE/BUSY request handshake toward the external calc engine.
module ahb_calc_chan
    import ahb_calc_pkg::*;
#(
    parameter int OP_W  = 16,
    parameter int RES_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_ctrl,
    input  logic             i_wr_opa,
    input  logic             i_wr_opb,
    input  logic             i_wr_stat,
    input  logic [31:0]      i_wdata,
    input  logic             i_ack,
    input  logic [RES_W-1:0] i_result,
    output logic             o_req,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_mode,
    output logic [OP_W-1:0]  o_opa,
    output logic [OP_W-1:0]  o_opb,
    output logic [RES_W-1:0] o_result
);

    logic             r_state;
    logic [1:0]       r_mode;
    logic [OP_W-1:0]  r_opa;
    logic [OP_W-1:0]  r_opb;
    logic [RES_W-1:0] r_result;
    logic             r_done;
    logic             w_idle;
    logic             w_ack;
    logic             w_unused;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_ack    = i_ack && !w_idle;
    assign w_unused = ^i_wdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_mode   <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            // Operands and mode are frozen while a request is outstanding
            if (i_wr_ctrl && w_idle) begin
                r_mode <= i_wdata[2:1];
                if (i_wdata[0])
                    r_state <= ST_BUSY;
            end
            if (i_wr_opa && w_idle)
                r_opa <= i_wdata[OP_W-1:0];
            if (i_wr_opb && w_idle)
                r_opb <= i_wdata[OP_W-1:0];
            if (w_ack) begin
                r_state  <= ST_IDLE;
                r_result <= i_result;
            end
            // Completion beats a same-cycle W1C
            if (w_ack)
                r_done <= 1'b1;
            else if (i_wr_stat && i_wdata[1])
                r_done <= 1'b0;
        end
    end

    assign o_req    = (r_state == ST_BUSY);
    assign o_busy   = (r_state == ST_BUSY);
    assign o_done   = r_done;
    assign o_mode   = r_mode;
    assign o_opa    = r_opa;
    assign o_opb    = r_opb;
    assign o_result = r_result;

endmodule

// File: rtl/ahb_calc_regbank.sv
// AHB-Lite slave fronting NUM_CH calculator channels plus IRQ_EN/IRQ_STAT.
// Define AHB_CALC_ERR_RESP_EN to answer illegal accesses with a two-cycle ERROR.
module ahb_calc_regbank
    import ahb_calc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int OP_W   = 16,
    parameter int RES_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic                     hsel,
    input  logic                     hwrite,
    input  logic                     hready,
    input  logic [2:0]               hsize,
    input  logic [1:0]               htrans,
    input  logic [2:0]               hburst,
    input  logic [31:0]              hwdata,
    input  logic [ADDR_W-1:0]        haddr,
    output logic                     hready_resp,
    output logic [1:0]               hresp,
    output logic [31:0]              hrdata,
    output logic [NUM_CH-1:0]        calc_req,
    output logic [2*NUM_CH-1:0]      calc_mode,
    output logic [OP_W*NUM_CH-1:0]   calc_opa,
    output logic [OP_W*NUM_CH-1:0]   calc_opb,
    input  logic [NUM_CH-1:0]        calc_ack,
    input  logic [RES_W*NUM_CH-1:0]  calc_result,
    output logic                     irq
);

    localparam int IDX_W = ADDR_W - 5;

    logic [1:0]               r_trans;
    logic                     r_write;
    logic [ADDR_W-1:0]        r_addr;
    logic [NUM_CH-1:0]        r_irq_en;
    logic                     r_irq;

    logic                     w_capture;
    logic                     w_valid;
    logic                     w_wr;
    logic                     w_rd;
    logic [ADDR_W-1:0]        w_waddr;
    logic [4:0]               w_off;
    logic [IDX_W-1:0]         w_ch_idx;
    logic                     w_off_ok;
    logic                     w_glb_en;
    logic                     w_glb_st;
    logic [NUM_CH-1:0]        w_hit;
    logic [NUM_CH-1:0]        w_busy;
    logic [NUM_CH-1:0]        w_done;
    logic [NUM_CH-1:0]        w_drop;
    logic [NUM_CH-1:0]        w_ro_wr;
    logic [NUM_CH-1:0][31:0]  w_ch_rd;
    logic [31:0]              w_rd_data;
    logic                     w_unused;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_trans <= HTRANS_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
        end else if (w_capture) begin
            r_trans <= htrans;
            r_write <= hwrite;
            r_addr  <= haddr;
        end else begin
            r_trans <= HTRANS_IDLE;
        end
    end

    assign w_valid  = (r_trans == HTRANS_NONSEQ) || (r_trans == HTRANS_SEQ);
    assign w_wr     = w_valid && r_write;
    assign w_rd     = w_valid && !r_write;
    assign w_waddr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_off    = w_waddr[4:0];
    assign w_ch_idx = r_addr[ADDR_W-1:5];
    assign w_off_ok = (w_off <= STAT_OFF);
    assign w_glb_en = (w_waddr == ADDR_W'(IRQ_EN_ADDR));
    assign w_glb_st = (w_waddr == ADDR_W'(IRQ_STAT_ADDR));
    assign w_unused = ^{hsize, hburst, r_addr[1:0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]       w_mode;
        logic [OP_W-1:0]  w_opa;
        logic [OP_W-1:0]  w_opb;
        logic [RES_W-1:0] w_res;

        assign w_hit[c] = (w_ch_idx == IDX_W'(c)) && w_off_ok;

        ahb_calc_chan #(.OP_W(OP_W), .RES_W(RES_W)) u_chan (
            .i_clk     (hclk),
            .i_rst     (hreset),
            .i_wr_ctrl (w_wr && w_hit[c] && (w_off == CTRL_OFF)),
            .i_wr_opa  (w_wr && w_hit[c] && (w_off == OPA_OFF)),
            .i_wr_opb  (w_wr && w_hit[c] && (w_off == OPB_OFF)),
            .i_wr_stat (w_wr && w_hit[c] && (w_off == STAT_OFF)),
            .i_wdata   (hwdata),
            .i_ack     (calc_ack[c]),
            .i_result  (calc_result[c*RES_W +: RES_W]),
            .o_req     (calc_req[c]),
            .o_busy    (w_busy[c]),
            .o_done    (w_done[c]),
            .o_mode    (w_mode),
            .o_opa     (w_opa),
            .o_opb     (w_opb),
            .o_result  (w_res)
        );

        assign calc_mode[2*c +: 2]      = w_mode;
        assign calc_opa[c*OP_W +: OP_W] = w_opa;
        assign calc_opb[c*OP_W +: OP_W] = w_opb;

        assign w_ch_rd[c] = !w_hit[c]               ? 32'd0 :
                            (w_off == CTRL_OFF)     ? {29'd0, w_mode, 1'b0} :
                            (w_off == OPA_OFF)      ? 32'(w_opa) :
                            (w_off == OPB_OFF)      ? 32'(w_opb) :
                            (w_off == RESULT_OFF)   ? 32'(w_res) :
                                                      {30'd0, w_done[c], w_busy[c]};

        // hit on an aligned offset <= STAT that is neither RESULT nor STAT: CTRL/OPA/OPB
        assign w_drop[c]  = w_wr && w_hit[c] && w_busy[c] &&
                            (w_off != RESULT_OFF) && (w_off != STAT_OFF);
        assign w_ro_wr[c] = w_wr && w_hit[c] && (w_off == RESULT_OFF);
    end

    always_comb begin
        w_rd_data = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_rd_data = w_rd_data | w_ch_rd[c];
        if (w_glb_en)
            w_rd_data = 32'(r_irq_en);
        if (w_glb_st)
            w_rd_data = 32'(r_irq_en & w_done);
    end

    assign hrdata = w_rd ? w_rd_data : 32'd0;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && w_glb_en)
                r_irq_en <= hwdata[NUM_CH-1:0];
            r_irq <= |(w_done & r_irq_en);
        end
    end

    assign irq = r_irq;

`ifdef AHB_CALC_ERR_RESP_EN
    logic w_mapped;
    logic w_err1;
    logic r_err2;

    assign w_mapped = (|w_hit) || w_glb_en || w_glb_st;
    assign w_err1   = w_valid && (!w_mapped || (|w_drop) || (|w_ro_wr) || (w_wr && w_glb_st));

    always_ff @(posedge hclk) begin
        if (hreset)
            r_err2 <= 1'b0;
        else
            r_err2 <= w_err1;
    end

    // The first ERROR cycle stalls the bus, so no new address phase is taken then
    assign w_capture   = hsel && hready && !w_err1;
    assign hready_resp = !w_err1;
    assign hresp       = (w_err1 || r_err2) ? HRESP_ERROR : HRESP_OKAY;
`else
    logic w_unused_err;

    assign w_unused_err = ^{w_drop, w_ro_wr};
    assign w_capture    = hsel && hready;
    assign hready_resp  = 1'b1;
    assign hresp        = HRESP_OKAY;
`endif

endmodule
